// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage (master)
// and the instruction memory (slave).
interface if_fetch_stage_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_data_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_data_i
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: presents the PC to a variable-latency instruction memory and fills
// the IF/ID register, parking a word in a one-entry buffer during ID stalls and honouring flushes.
module if_fetch_stage (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      pc_i,
  output logic             pcWrite_o,
  input  logic             stall_i,
  input  logic             flush_i,
  if_fetch_stage_if.master imem,
  output logic             if_valid_o,
  output logic [31:0]      if_pc_o,
  output logic [31:0]      if_pc4_o,
  output logic [31:0]      if_inst_o
);

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {START, REQ, HOLD, DRAIN} state_t;

  state_t      state_q;
  logic        req_q;
  logic [31:0] addr_q;
  logic [31:0] hold_pc_q;
  logic [31:0] hold_inst_q;

  logic        ack;
  logic [31:0] rdata;
  logic        ifid_load;
  logic        nxt_valid;
  logic [31:0] nxt_pc;
  logic [31:0] nxt_inst;

  assign ack              = imem.imem_ack_i;
  assign rdata            = imem.imem_data_i;
  assign imem.imem_req_o  = req_q;
  // While draining a flushed request the address must stay on the one still in flight.
  assign imem.imem_addr_o = (state_q == REQ) ? pc_i : addr_q;

  // IF/ID load decision and PC advance; defaults describe a bubble that is not loaded.
  always_comb begin
    pcWrite_o = 1'b0;
    ifid_load = 1'b0;
    nxt_valid = 1'b0;
    nxt_pc    = 32'h0000_0000;
    nxt_inst  = NOP;
    case (state_q)
      REQ: begin
        if (flush_i) begin
          pcWrite_o = 1'b1;
          ifid_load = 1'b1;
        end else if (stall_i) begin
          pcWrite_o = 1'b0;
        end else if (ack) begin
          pcWrite_o = 1'b1;
          ifid_load = 1'b1;
          nxt_valid = 1'b1;
          nxt_pc    = pc_i;
          nxt_inst  = rdata;
        end else begin
          ifid_load = 1'b1;
        end
      end
      HOLD: begin
        if (flush_i) begin
          pcWrite_o = 1'b1;
          ifid_load = 1'b1;
        end else if (!stall_i) begin
          pcWrite_o = 1'b1;
          ifid_load = 1'b1;
          nxt_valid = 1'b1;
          nxt_pc    = hold_pc_q;
          nxt_inst  = hold_inst_q;
        end
      end
      DRAIN: begin
        pcWrite_o = flush_i;
        ifid_load = flush_i | ~stall_i;
      end
      default: begin
        pcWrite_o = 1'b0;
      end
    endcase
  end

  // Sequencer plus IF/ID and hold-buffer registers; the request line is registered with the state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= START;
      req_q       <= 1'b0;
      addr_q      <= 32'h0000_0000;
      hold_pc_q   <= 32'h0000_0000;
      hold_inst_q <= NOP;
      if_valid_o  <= 1'b0;
      if_pc_o     <= 32'h0000_0000;
      if_pc4_o    <= 32'h0000_0000;
      if_inst_o   <= NOP;
    end else begin
      if (ifid_load) begin
        if_valid_o <= nxt_valid;
        if_pc_o    <= nxt_pc;
        if_pc4_o   <= nxt_pc + 32'd4;
        if_inst_o  <= nxt_inst;
      end
      case (state_q)
        START: begin
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: begin
          addr_q <= pc_i;
          if (flush_i) begin
            if (!ack) state_q <= DRAIN;
          end else if (stall_i && ack) begin
            hold_pc_q   <= pc_i;
            hold_inst_q <= rdata;
            state_q     <= HOLD;
            req_q       <= 1'b0;
          end
        end
        HOLD: begin
          if (flush_i || !stall_i) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        DRAIN: begin
          if (ack) state_q <= REQ;
        end
        default: begin
          state_q <= START;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage sitting directly downstream of the program counter register. Each cycle it presents the current PC to a variable-latency instruction memory, captures the returned word into the IF/ID pipeline register, and pulses the PC write-enable so the PC advances. It absorbs ID-stage stalls with a one-entry hold buffer and honours branch flushes, including responses still in flight.

## Interface
- NOP, 32'h00000000, instruction word inserted as a bubble
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- pc_i  in  32  current PC value
- pcWrite_o  out  1  PC write-enable, combinational
- stall_i  in  1  ID stage cannot accept (load-use hazard)
- flush_i  in  1  branch taken in ID; PC input mux selects target this cycle
- imem_req_o  out  1  fetch request, held until ack
- imem_addr_o  out  32  fetch address, stable while imem_req_o=1
- imem_ack_i  in  1  response valid this cycle; may be same cycle as request
- imem_data_i  in  32  instruction word, valid with imem_ack_i
- if_valid_o  out  1  IF/ID holds a real instruction
- if_pc_o  out  32  PC of IF/ID instruction
- if_pc4_o  out  32  if_pc_o + 4, modulo 2^32
- if_inst_o  out  32  IF/ID instruction word

## Operation
- Async reset: state START; if_valid_o=0, if_pc_o=0, if_pc4_o=0, if_inst_o=NOP, hold buffer empty, addr_q=0.
- States:
  - START: imem_req_o=0, pcWrite_o=0. Next state REQ unconditionally.
  - REQ: imem_req_o=1, imem_addr_o=pc_i. addr_q<=pc_i every cycle.
  - HOLD: imem_req_o=0. Word in hold buffer, waiting for stall_i to drop.
  - DRAIN: imem_req_o=1, imem_addr_o=addr_q. Waiting for the response to a flushed request.
- Priority, each cycle: flush_i > stall_i > delivery.
- REQ transitions:
  - flush_i, ack: discard word, pcWrite_o=1, IF/ID loads bubble, stay REQ.
  - flush_i, no ack: pcWrite_o=1, IF/ID loads bubble, go DRAIN.
  - ack, no stall: IF/ID loads {1, pc_i, pc_i+4, imem_data_i}, pcWrite_o=1, stay REQ.
  - ack, stall: buffer {pc_i, imem_data_i}, pcWrite_o=0, IF/ID holds, go HOLD.
  - no ack, stall: IF/ID holds. No ack, no stall: IF/ID loads bubble.
- HOLD transitions:
  - flush_i: discard buffer, pcWrite_o=1, IF/ID loads bubble, go REQ.
  - stall_i: IF/ID holds, pcWrite_o=0.
  - Otherwise: IF/ID loads buffered word with valid=1, pcWrite_o=1, go REQ.
- DRAIN:
  - ack: discard the word and go REQ.
  - stall_i=0: IF/ID loads bubble each cycle. stall_i=1: IF/ID holds.
  - pcWrite_o=flush_i. A second flush re-steers the PC; stay DRAIN.
- Bubble = {valid=0, pc=0, pc4=4, inst=NOP}.
- pcWrite_o is never 1 in START.

## Timing
- Zero-wait memory (ack in same cycle as req): one instruction per cycle. Ack at cycle N gives IF/ID valid at N+1; PC updated at edge N+1; next request at N+1.
- k wait states: one delivery every k+1 cycles; k bubbles between deliveries.
- HOLD exit: stall_i falls in cycle M; IF/ID valid at M+1; new request at M+1.
- DRAIN: the address in flight never changes while imem_req_o=1. Exactly one response is consumed per request.
- Reset mid-operation in any state: immediate return to reset values. Any memory response after reset deassertion, before the first REQ cycle, is ignored.
- if_pc4_o wraps: pc 32'hFFFFFFFC gives 32'h00000000.

## Test plan
- Zero-wait memory, imem_data_i=addr^32'hA5A5A5A5, reset released → START for 1 cycle, then if_pc_o=0,4,8,… on consecutive cycles with if_valid_o=1, and pcWrite_o=1 every REQ cycle.
- Memory with 2 wait states → if_valid_o pattern 0,0,1 repeating; bubbles show if_inst_o=0; pcWrite_o high 1 cycle in 3.
- Ack for pc 0x10 while stall_i=1, stall held 3 cycles → HOLD: imem_req_o=0, pcWrite_o=0, IF/ID unchanged. Cycle after stall drops: if_pc_o=0x10, if_valid_o=1.
- Request to 0x20 outstanding, flush_i with PC target 0x100, ack 2 cycles later → imem_addr_o stays 0x20 through DRAIN, data discarded, if_valid_o=0, next request address 0x100.
- flush_i coincident with ack at 0x30 → word dropped, pcWrite_o=1, IF/ID bubble, next address = branch target. Same check with flush_i in HOLD → buffer discarded.
- rst_i asserted mid-HOLD and mid-DRAIN → outputs immediately at reset values, imem_req_o=0, START on release; pc 0xFFFFFFFC fetch gives if_pc4_o=0.
